// File: rtl/butterfly_pipe_if.sv
// rtl/butterfly_pipe_if.sv - handshake and data bundle for the pipelined butterfly
interface butterfly_pipe_if #(
  parameter int WIDTH     = 16,
  parameter int TW_WIDTH  = 16,
  parameter int TAG_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_real_1;
  logic [WIDTH-1:0]     in_complex_1;
  logic [WIDTH-1:0]     in_real_2;
  logic [WIDTH-1:0]     in_complex_2;
  logic [TW_WIDTH-1:0]  tw_real;
  logic [TW_WIDTH-1:0]  tw_complex;
  logic                 in_scale;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_real_1;
  logic [WIDTH-1:0]     out_complex_1;
  logic [WIDTH-1:0]     out_real_2;
  logic [WIDTH-1:0]     out_complex_2;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_sat;
  logic                 sat_sticky;
  logic                 sat_clear;

  modport slave (
    input  in_valid, in_real_1, in_complex_1, in_real_2, in_complex_2,
           tw_real, tw_complex, in_scale, in_tag, out_ready, sat_clear,
    output in_ready, out_valid, out_real_1, out_complex_1, out_real_2,
           out_complex_2, out_tag, out_sat, sat_sticky
  );

  modport master (
    output in_valid, in_real_1, in_complex_1, in_real_2, in_complex_2,
           tw_real, tw_complex, in_scale, in_tag, out_ready, sat_clear,
    input  in_ready, out_valid, out_real_1, out_complex_1, out_real_2,
           out_complex_2, out_tag, out_sat, sat_sticky
  );
endinterface

// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - three-stage radix-2 DIT butterfly with twiddle, scaling and saturation
module butterfly_pipe #(
  parameter int WIDTH     = 16,
  parameter int TW_WIDTH  = 16,
  parameter int TAG_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  butterfly_pipe_if.slave bus
);
  localparam int PW = WIDTH + TW_WIDTH + 1;
  localparam int SW = WIDTH + 2;
  localparam logic signed [PW-1:0] RND  = {{(PW-TW_WIDTH+1){1'b0}}, 1'b1, {(TW_WIDTH-2){1'b0}}};
  localparam logic signed [SW-1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};

  logic                        advance;
  logic                        s1_valid, s1_scale;
  logic signed [WIDTH-1:0]     s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [TW_WIDTH-1:0]  s1_wr, s1_wi;
  logic [TAG_WIDTH-1:0]        s1_tag;
  logic                        s2_valid, s2_scale;
  logic signed [WIDTH-1:0]     s2_ar, s2_ai;
  logic signed [SW-1:0]        s2_tr, s2_ti;
  logic [TAG_WIDTH-1:0]        s2_tag;
  logic                        o_valid, o_sat, o_sticky;
  logic [WIDTH-1:0]            o_r1, o_c1, o_r2, o_c2;
  logic [TAG_WIDTH-1:0]        o_tag;

  logic signed [PW-1:0]        p_re, p_im;
  logic signed [SW-1:0]        t_re, t_im, u_re, u_im, d_re, d_im;
  logic [WIDTH:0]              q_r1, q_c1, q_r2, q_c2;
  logic                        any_clip;

  function automatic logic signed [SW-1:0] half(input logic signed [SW-1:0] v, input logic en);
    half = en ? ((v + SW'(1)) >>> 1) : v;
  endfunction

  // Returns {clipped, value}
  function automatic logic [WIDTH:0] clip(input logic signed [SW-1:0] v);
    if (v > MAXV)      clip = {1'b1, MAXV[WIDTH-1:0]};
    else if (v < MINV) clip = {1'b1, MINV[WIDTH-1:0]};
    else               clip = {1'b0, v[WIDTH-1:0]};
  endfunction

  always_comb begin
    p_re = PW'(s1_br) * PW'(s1_wr) - PW'(s1_bi) * PW'(s1_wi);
    p_im = PW'(s1_br) * PW'(s1_wi) + PW'(s1_bi) * PW'(s1_wr);
    t_re = SW'((p_re + RND) >>> (TW_WIDTH - 1));
    t_im = SW'((p_im + RND) >>> (TW_WIDTH - 1));
    u_re = half(SW'(s2_ar) + s2_tr, s2_scale);
    u_im = half(SW'(s2_ai) + s2_ti, s2_scale);
    d_re = half(SW'(s2_ar) - s2_tr, s2_scale);
    d_im = half(SW'(s2_ai) - s2_ti, s2_scale);
    q_r1 = clip(d_re);
    q_c1 = clip(d_im);
    q_r2 = clip(u_re);
    q_c2 = clip(u_im);
    any_clip = q_r1[WIDTH] | q_c1[WIDTH] | q_r2[WIDTH] | q_c2[WIDTH];
  end

  // Every stage moves together, so empty stages never hold back later samples.
  assign advance           = !o_valid || bus.out_ready;
  assign bus.in_ready      = advance;
  assign bus.out_valid     = o_valid;
  assign bus.out_real_1    = o_r1;
  assign bus.out_complex_1 = o_c1;
  assign bus.out_real_2    = o_r2;
  assign bus.out_complex_2 = o_c2;
  assign bus.out_tag       = o_tag;
  assign bus.out_sat       = o_sat;
  assign bus.sat_sticky    = o_sticky;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_scale <= 1'b0; s1_tag <= '0;
      s1_ar <= '0; s1_ai <= '0; s1_br <= '0; s1_bi <= '0; s1_wr <= '0; s1_wi <= '0;
      s2_valid <= 1'b0; s2_scale <= 1'b0; s2_tag <= '0;
      s2_ar <= '0; s2_ai <= '0; s2_tr <= '0; s2_ti <= '0;
      o_valid <= 1'b0; o_sat <= 1'b0; o_sticky <= 1'b0; o_tag <= '0;
      o_r1 <= '0; o_c1 <= '0; o_r2 <= '0; o_c2 <= '0;
    end else begin
      if (advance) begin
        s1_valid <= bus.in_valid;
        s1_ar    <= bus.in_real_1;
        s1_ai    <= bus.in_complex_1;
        s1_br    <= bus.in_real_2;
        s1_bi    <= bus.in_complex_2;
        s1_wr    <= bus.tw_real;
        s1_wi    <= bus.tw_complex;
        s1_scale <= bus.in_scale;
        s1_tag   <= bus.in_tag;
        s2_valid <= s1_valid;
        s2_ar    <= s1_ar;
        s2_ai    <= s1_ai;
        s2_tr    <= t_re;
        s2_ti    <= t_im;
        s2_scale <= s1_scale;
        s2_tag   <= s1_tag;
        o_valid  <= s2_valid;
        o_sat    <= s2_valid & any_clip;
        o_r1     <= q_r1[WIDTH-1:0];
        o_c1     <= q_c1[WIDTH-1:0];
        o_r2     <= q_r2[WIDTH-1:0];
        o_c2     <= q_c2[WIDTH-1:0];
        o_tag    <= s2_tag;
      end
      if (bus.sat_clear)
        o_sticky <= 1'b0;
      else if (advance && s2_valid && any_clip)
        o_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - directed and randomized checks of butterfly_pipe against a behavioural model
module tb_butterfly_pipe;
  localparam int W  = 16;
  localparam int TW = 16;
  localparam int TG = 8;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));
  localparam longint D    = longint'(1) << (TW - 1);

  typedef struct {
    longint o1r, o1i, o2r, o2i;
    int     sat;
    int     tag;
    int     cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  butterfly_pipe_if #(.WIDTH(W), .TW_WIDTH(TW), .TAG_WIDTH(TG)) bus ();
  butterfly_pipe #(.WIDTH(W), .TW_WIDTH(TW), .TAG_WIDTH(TG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t exp_q[$];
  res_t hold;
  int   n_cmp = 0, n_bad = 0, cyc = 0, n_pop = 0;
  bit   strict = 1'b0, held = 1'b0, s_in_xfer = 1'b0;
  logic s_ov;
  int   d_ar, d_ai, d_br, d_bi, d_wr, d_wi, d_tag;
  bit   d_sc;

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(longint x, longint d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic res_t model(int ar, int ai, int br, int bi, int wr, int wi, bit sc, int tag);
    res_t   r;
    longint pr, pi, tr, ti;
    longint s[4];
    pr = longint'(br) * wr - longint'(bi) * wi;
    pi = longint'(br) * wi + longint'(bi) * wr;
    tr = fdiv(pr + D / 2, D);
    ti = fdiv(pi + D / 2, D);
    s[0] = ar - tr; s[1] = ai - ti; s[2] = ar + tr; s[3] = ai + ti;
    r.sat = 0;
    for (int k = 0; k < 4; k++) begin
      if (sc) s[k] = fdiv(s[k] + 1, 2);
      if (s[k] > MAXV) begin s[k] = MAXV; r.sat = 1; end
      else if (s[k] < MINV) begin s[k] = MINV; r.sat = 1; end
    end
    r.o1r = s[0]; r.o1i = s[1]; r.o2r = s[2]; r.o2i = s[3];
    r.tag = tag & ((1 << TG) - 1);
    r.cyc = cyc;
    return r;
  endfunction

  function automatic int rnd_v();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return int'(MINV);
    if (sel == 1) return int'(MAXV);
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic drive(bit v, int ar, int ai, int br, int bi, int wr, int wi, bit sc, int tag);
    d_ar = ar; d_ai = ai; d_br = br; d_bi = bi; d_wr = wr; d_wi = wi; d_sc = sc; d_tag = tag;
    bus.in_valid     = v;
    bus.in_real_1    = ar[W-1:0];
    bus.in_complex_1 = ai[W-1:0];
    bus.in_real_2    = br[W-1:0];
    bus.in_complex_2 = bi[W-1:0];
    bus.tw_real      = wr[TW-1:0];
    bus.tw_complex   = wi[TW-1:0];
    bus.in_scale     = sc;
    bus.in_tag       = tag[TG-1:0];
  endtask

  task automatic drive_rand(bit v, int tag);
    drive(v, rnd_v(), rnd_v(), rnd_v(), rnd_v(), rnd_v(), rnd_v(), ($urandom_range(0, 1) == 1), tag);
  endtask

  // One clock cycle: sample at the falling edge, score, then step past the rising edge.
  task automatic step();
    res_t e;
    @(negedge clk);
    s_ov = bus.out_valid;
    s_in_xfer = 1'b0;
    chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
    if (held) begin
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_o1r", $signed(bus.out_real_1), hold.o1r);
      chk("hold_o1i", $signed(bus.out_complex_1), hold.o1i);
      chk("hold_o2r", $signed(bus.out_real_2), hold.o2r);
      chk("hold_o2i", $signed(bus.out_complex_2), hold.o2i);
      chk("hold_tag", bus.out_tag, hold.tag);
      chk("hold_sat", bus.out_sat, hold.sat);
    end
    if (exp_q.size() == 0) begin
      chk("idle_out_valid", bus.out_valid, 1'b0);
    end else if (bus.out_valid && bus.out_ready) begin
      e = exp_q.pop_front();
      n_pop++;
      chk("out_real_1", $signed(bus.out_real_1), e.o1r);
      chk("out_complex_1", $signed(bus.out_complex_1), e.o1i);
      chk("out_real_2", $signed(bus.out_real_2), e.o2r);
      chk("out_complex_2", $signed(bus.out_complex_2), e.o2i);
      chk("out_tag", bus.out_tag, e.tag);
      chk("out_sat", bus.out_sat, e.sat);
      if (strict) chk("latency", cyc - e.cyc, 3);
    end
    held = bus.out_valid && !bus.out_ready;
    if (held) begin
      hold.o1r = $signed(bus.out_real_1);
      hold.o1i = $signed(bus.out_complex_1);
      hold.o2r = $signed(bus.out_real_2);
      hold.o2i = $signed(bus.out_complex_2);
      hold.tag = int'(bus.out_tag);
      hold.sat = int'(bus.out_sat);
    end
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(d_ar, d_ai, d_br, d_bi, d_wr, d_wi, d_sc, d_tag));
      s_in_xfer = 1'b1;
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end
    #1;
  endtask

  task automatic chk_zero_outputs(string pfx);
    chk({pfx, "_out_valid"}, bus.out_valid, 1'b0);
    chk({pfx, "_in_ready"}, bus.in_ready, 1'b1);
    chk({pfx, "_out_sat"}, bus.out_sat, 1'b0);
    chk({pfx, "_sat_sticky"}, bus.sat_sticky, 1'b0);
    chk({pfx, "_out_real_1"}, bus.out_real_1, 0);
    chk({pfx, "_out_complex_1"}, bus.out_complex_1, 0);
    chk({pfx, "_out_real_2"}, bus.out_real_2, 0);
    chk({pfx, "_out_complex_2"}, bus.out_complex_2, 0);
    chk({pfx, "_out_tag"}, bus.out_tag, 0);
  endtask

  initial begin
    int pat[7];
    int exp_ov[7];
    int obs_ov[7];
    int idx;
    int pops0;
    pat    = '{1, 0, 0, 1, 0, 0, 0};
    exp_ov = '{0, 0, 0, 1, 0, 0, 1};

    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.sat_clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_zero_outputs("reset");

    strict = 1'b1;
    drive(1, 1000, 0, 1000, 0, 32767, 0, 0, 8'h11);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("unity_not_early", bus.out_valid, 1'b0);
    step();
    chk("unity_valid", bus.out_valid, 1'b1);
    chk("unity_o2r", $signed(bus.out_real_2), 2000);
    chk("unity_o2i", $signed(bus.out_complex_2), 0);
    chk("unity_o1r", $signed(bus.out_real_1), 0);
    chk("unity_o1i", $signed(bus.out_complex_1), 0);
    step();

    drive(1, 0, 0, 100, 200, 0, -32768, 0, 2);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("mj_o2r", $signed(bus.out_real_2), 200);
    chk("mj_o2i", $signed(bus.out_complex_2), -100);
    chk("mj_o1r", $signed(bus.out_real_1), -200);
    chk("mj_o1i", $signed(bus.out_complex_1), 100);
    step();

    drive(1, 30000, 0, 30000, 0, -32768, 0, 0, 3);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("sat_o1r", $signed(bus.out_real_1), 32767);
    chk("sat_o1i", $signed(bus.out_complex_1), 0);
    chk("sat_o2r", $signed(bus.out_real_2), 0);
    chk("sat_o2i", $signed(bus.out_complex_2), 0);
    chk("sat_flag", bus.out_sat, 1'b1);
    chk("sat_sticky_set", bus.sat_sticky, 1'b1);
    step();

    drive(1, 30000, 0, 30000, 0, -32768, 0, 1, 4);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("scaled_o1r", $signed(bus.out_real_1), 30000);
    chk("scaled_sat", bus.out_sat, 1'b0);
    chk("scaled_sticky_kept", bus.sat_sticky, 1'b1);
    step();

    bus.sat_clear = 1'b1;
    step();
    bus.sat_clear = 1'b0;
    chk("sticky_cleared", bus.sat_sticky, 1'b0);

    drive(1, 30000, 0, 30000, 0, -32768, 0, 0, 5);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    bus.sat_clear = 1'b1;
    step();
    bus.sat_clear = 1'b0;
    chk("clr_pri_valid", bus.out_valid, 1'b1);
    chk("clr_pri_out_sat", bus.out_sat, 1'b1);
    chk("clr_pri_sticky", bus.sat_sticky, 1'b0);
    step();

    for (int k = 0; k < 7; k++) begin
      drive_rand(pat[k] == 1, 8'h40 + k);
      step();
      obs_ov[k] = int'(s_ov);
    end
    for (int k = 0; k < 7; k++) chk($sformatf("bubble_ov%0d", k), obs_ov[k], exp_ov[k]);

    strict = 1'b0;
    idx = 0;
    pops0 = n_pop;
    for (int n = 0; n < 300 && (idx < 8 || exp_q.size() > 0); n++) begin
      drive_rand(idx < 8, idx);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      step();
      if (s_in_xfer) idx++;
    end
    bus.out_ready = 1'b1;
    chk("bp_sent", idx, 8);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_pops", n_pop - pops0, 8);

    for (int n = 0; n < 400; n++) begin
      drive_rand($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) step();
    chk("rand_drained", exp_q.size(), 0);

    strict = 1'b1;
    drive(1, 30000, 0, 30000, 0, -32768, 0, 0, 8'h20);
    step();
    drive_rand(1, 8'h21);
    step();
    drive_rand(1, 8'h22);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_zero_outputs("midrst");
    repeat (5) step();
    drive(1, 1000, 0, 1000, 0, 32767, 0, 0, 8'h23);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("post_rst_valid", bus.out_valid, 1'b1);
    chk("post_rst_tag", bus.out_tag, 8'h23);
    step();
    chk("post_rst_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Pipelined, parametrised radix-2 decimation-in-time butterfly for the FFT datapath. It is the successor to the combinational add/sub butterfly. It multiplies the second operand by a per-sample twiddle factor and applies optional per-sample divide-by-2 scaling with rounding. Outputs are saturated to the data width and reported through overflow flags. A valid/ready handshake with full backpressure lets the FFT stage controller stall it.

## Interface
- WIDTH, 16: data width of each real/imaginary component, two's complement.
- TW_WIDTH, 16: twiddle component width, signed Q1.(TW_WIDTH-1).
- TAG_WIDTH, 8: sideband tag (e.g. bin index) carried alongside the data, unmodified.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_real_1, in_complex_1  in  WIDTH each  operand a.
- in_real_2, in_complex_2  in  WIDTH each  operand b.
- tw_real, tw_complex  in  TW_WIDTH each  twiddle w for this sample.
- in_scale  in  1  when 1, results are halved with rounding.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts output.
- out_real_1, out_complex_1  out  WIDTH each  a − w·b.
- out_real_2, out_complex_2  out  WIDTH each  a + w·b.
- out_tag  out  TAG_WIDTH  tag of this result.
- out_sat  out  1  at least one of the four components of this result saturated.
- sat_sticky  out  1  a saturation has occurred since reset or clear.
- sat_clear  in  1  clears sat_sticky.

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Three pipeline stages, all advancing together on advance = !out_valid || out_ready. in_ready = advance (combinational).
- S1 registers the operands, twiddle, scale and tag, plus a valid bit.
- S2 forms the twiddled product t = w·b:
  - t_re = b_re·w_re − b_im·w_im.
  - t_im = b_re·w_im + b_im·w_re.
  - Products are full precision, WIDTH+TW_WIDTH+1 bits.
  - Rounding: add 2^(TW_WIDTH−2), then arithmetic shift right by TW_WIDTH−1 (round-half-up). Keep WIDTH+2 bits, with no truncation at this step.
  - a, scale and tag are delayed alongside.
- S3 computes the sums and differences:
  - s2 = a + t and s1 = a − t, in WIDTH+2 bits.
  - If scale: add 1, then arithmetic shift right by 1.
  - Saturate each component to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - out_sat = OR of the four clip events.
- sat_sticky:
  - Set on the cycle a result with out_sat=1 is loaded into S3.
  - sat_clear has priority over a simultaneous set.
- Valid bubbles propagate. Empty stages still advance, so a bubble never blocks a later sample.
- Twiddle +1.0 is not representable; 2^(TW_WIDTH−1)−1 is used instead. −1.0 is exact.

## Timing
- Latency: 3 cycles from input transfer to out_valid, with out_ready held high.
- Throughput: 1 transaction per cycle with out_ready high.
- Backpressure: when out_valid && !out_ready, all stages hold their data and valids, and in_ready = 0. Nothing is dropped or duplicated.
- Outputs are stable while out_valid && !out_ready.
- Reset (rst_n=0 at a clock edge):
  - All stage valids, out_valid, out_sat and sat_sticky go to 0.
  - All data outputs and out_tag go to 0.
  - in_ready reads 1 on the first cycle after reset.
- Reset mid-stream discards all in-flight samples. No output is produced for them.
- sat_clear and a saturating load in the same cycle: sat_sticky = 0. out_sat still shows 1.

## Test plan
Values below use WIDTH=16 and TW_WIDTH=16.
- Unity twiddle: a=(1000,0), b=(1000,0), w=(32767,0), scale=0 -> out_2=(2000,0), out_1=(0,0), out_valid exactly 3 cycles after transfer.
- −j twiddle: a=(0,0), b=(100,200), w=(0,−32768) -> out_2=(200,−100), out_1=(−200,100).
- Saturation and scaling:
  - a=(30000,0), b=(30000,0), w=(−32768,0), scale=0 -> out_1=(32767,0), out_2=(0,0), out_sat=1, sat_sticky=1.
  - The same input with scale=1 -> out_1=(30000,0), out_sat=0.
  - sat_clear pulse -> sat_sticky=0.
- Backpressure: stream 8 samples with tags 0..7 while out_ready toggles in a pseudo-random pattern -> all 8 results appear in tag order, each exactly once, and outputs are held constant while stalled.
- Bubbles: in_valid pattern 1,0,0,1 with out_ready=1 -> out_valid pattern 1,0,0,1 starting 3 cycles later.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight -> no out_valid for those samples, all outputs 0, and a new sample after reset completes with 3-cycle latency.
